// File: rtl/opb_ppc2sim_pkg.sv
// Shared constants for the PPC-to-Simulink OPB register bank.
// Holds the slave FSM state encoding and the bus geometry constants.
package opb_ppc2sim_pkg;

  localparam int OPB_DW    = 32;
  localparam int NUM_LANES = 4;
  localparam int MAX_REGS  = 16;
  localparam int IDX_W     = $clog2(MAX_REGS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave handshake: address-window decode, IDLE/ACK/HOLD sequencing, xferAck.
// A hit sampled in IDLE raises xferAck for exactly the next cycle; HOLD then
// swallows one cycle so a master still holding select cannot get a double ack.
module opb_slave_ack_fsm
  import opb_ppc2sim_pkg::*;
#(
  parameter int                      C_OPB_AWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR   = '1,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR   = '0,
  parameter int                      C_NUM_REGS   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [C_OPB_AWIDTH-1:0] abus_i,
  input  logic                    rnw_i,
  input  logic                    select_i,
  output logic                    start_o,
  output logic [IDX_W-1:0]        idx_o,
  output logic                    in_range_o,
  output logic [IDX_W-1:0]        idx_q_o,
  output logic                    rnw_q_o,
  output logic                    in_range_q_o,
  output logic                    ack_cycle_o,
  output logic                    xfer_ack_o
);

  localparam logic [C_OPB_AWIDTH-3:0] NUM_WORDS = (C_OPB_AWIDTH-2)'(C_NUM_REGS);

  logic [1:0]              state_q, state_d;
  logic                    ack_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    rnw_q;
  logic                    in_range_q;
  logic [C_OPB_AWIDTH-1:0] offset;
  logic                    hit;

  // The register index comes from offset bits [5:2]; the full word offset decides
  // whether the index is real, so window addresses past the last register
  // are acked but never alias onto a low register.
  assign offset     = abus_i - C_BASEADDR;
  assign hit        = select_i && (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);
  assign idx_o      = offset[IDX_W+1:2];
  assign in_range_o = (offset[C_OPB_AWIDTH-1:2] < NUM_WORDS);
  assign start_o    = (state_q == ST_IDLE) && hit;

  // Next-state: bus inputs only matter in IDLE; ACK and HOLD are fixed one-cycle steps.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, registered ack, and the transfer attributes captured on acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ack_q      <= 1'b0;
      idx_q      <= '0;
      rnw_q      <= 1'b0;
      in_range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ST_ACK);
      if (start_o) begin
        idx_q      <= idx_o;
        rnw_q      <= rnw_i;
        in_range_q <= in_range_o;
      end
    end
  end

  assign idx_q_o      = idx_q;
  assign rnw_q_o      = rnw_q;
  assign in_range_q_o = in_range_q;
  assign ack_cycle_o  = ack_q;
  assign xfer_ack_o   = ack_q;

endmodule

// File: rtl/opb_register_ppc2simulink_bank.sv
// OPB slave bank of software-written control registers driven out to user logic.
// Writes commit on the edge entering ACK (visible and strobed during ACK); reads
// return data only in the ACK cycle, otherwise the slave drives 0 onto the OR-bus.
module opb_register_ppc2simulink_bank
  import opb_ppc2sim_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h00000000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5",
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RST_VAL    = 32'h00000000
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_xferAck,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0]  user_data_out,
  output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

  logic              start;
  logic [IDX_W-1:0]  idx, idx_q;
  logic              in_range, in_range_q, rnw_q, ack_cycle;
  logic [OPB_DW-1:0] wdata, rdata;
  logic [NUM_LANES-1:0] lane_en;
  logic [OPB_DW-1:0] regs_q [C_NUM_REGS];
  logic [OPB_DW-1:0] regs_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] strobe_q, strobe_d;
  logic              unused_seq;

  // Bursts are treated beat by beat, so the sequential hint carries no meaning here.
  assign unused_seq = OPB_seqAddr;

  // Big-endian bus: DBus[0:7] / BE[0] is the most significant byte, so a plain
  // MSB-aligned copy puts lane k onto register bits [31-8k:24-8k].
  assign wdata   = OPB_DBus;
  assign lane_en = OPB_BE;

  opb_slave_ack_fsm #(
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_NUM_REGS   (C_NUM_REGS)
  ) u_fsm (
    .clk_i        (OPB_Clk),
    .rst_i        (OPB_Rst),
    .abus_i       (OPB_ABus),
    .rnw_i        (OPB_RNW),
    .select_i     (OPB_select),
    .start_o      (start),
    .idx_o        (idx),
    .in_range_o   (in_range),
    .idx_q_o      (idx_q),
    .rnw_q_o      (rnw_q),
    .in_range_q_o (in_range_q),
    .ack_cycle_o  (ack_cycle),
    .xfer_ack_o   (Sl_xferAck)
  );

  // Register update and strobe for an accepted in-range write; only enabled lanes move.
  always_comb begin
    strobe_d = '0;
    for (int r = 0; r < C_NUM_REGS; r++) begin
      regs_d[r] = regs_q[r];
      if (start && !OPB_RNW && in_range && (idx == IDX_W'(r))) begin
        strobe_d[r] = 1'b1;
        for (int b = 0; b < NUM_LANES; b++) begin
          if (lane_en[b]) regs_d[r][8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Register array and one-cycle strobes; reset wins immediately.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int r = 0; r < C_NUM_REGS; r++) regs_q[r] <= C_RST_VAL;
      strobe_q <= '0;
    end else begin
      for (int r = 0; r < C_NUM_REGS; r++) regs_q[r] <= regs_d[r];
      strobe_q <= strobe_d;
    end
  end

  // Read mux: nonzero only while acking an in-range read.
  always_comb begin
    rdata = '0;
    if (ack_cycle && rnw_q && in_range_q) begin
      for (int r = 0; r < C_NUM_REGS; r++) begin
        if (idx_q == IDX_W'(r)) rdata = regs_q[r];
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs_q[g];
  end

  assign user_wr_strobe = strobe_q;
  assign Sl_DBus        = rdata;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

endmodule

// File: tb/tb_opb_register_ppc2simulink_bank.sv
// Bench for the PPC-to-Simulink OPB register bank.
// Table of single transfers scored through an expected-ack queue, then
// hand sequences for a held select and for reset during an ACK cycle.
module tb_opb_register_ppc2simulink_bank;

  localparam logic [31:0] BASE = 32'h01008700;
  localparam logic [31:0] HIGH = 32'h010087FF;

  logic         OPB_Clk = 1'b0;
  logic         OPB_Rst;
  logic [0:31]  OPB_ABus;
  logic [0:3]   OPB_BE;
  logic [0:31]  OPB_DBus;
  logic         OPB_RNW, OPB_select, OPB_seqAddr;
  logic [0:31]  Sl_DBus;
  logic         Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;
  logic [127:0] user_data_out;
  logic [3:0]   user_wr_strobe;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_register_ppc2simulink_bank #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_FAMILY("virtex5"), .C_NUM_REGS(4), .C_RST_VAL(32'h00000000)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select),
    .OPB_seqAddr(OPB_seqAddr), .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck),
    .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .user_data_out(user_data_out), .user_wr_strobe(user_wr_strobe)
  );

  typedef struct {
    logic [31:0] addr;
    logic [0:3]  be;
    logic [31:0] data;
    logic        rnw;
    logic        exp_ack;
    logic [31:0] exp_dbus;
    logic [3:0]  exp_strb;
    int          ridx;
    logic [31:0] exp_reg;
  } vec_t;

  typedef struct {
    logic [31:0] dbus;
    logic [3:0]  strb;
  } sb_t;

  vec_t        vecs[17];
  sb_t         sbq[$];
  logic [31:0] model[4];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [127:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic vec_t mk(input logic [31:0] off, input logic [0:3] be, input logic [31:0] d,
                              input logic rnw, input logic ack, input logic [31:0] edb,
                              input logic [3:0] es, input int ri, input logic [31:0] er);
    vec_t v;
    v.addr = off; v.be = be; v.data = d; v.rnw = rnw; v.exp_ack = ack;
    v.exp_dbus = edb; v.exp_strb = es; v.ridx = ri; v.exp_reg = er;
    return v;
  endfunction

  // Scoreboard: every ack seen pops one expectation.
  always @(negedge OPB_Clk) begin
    if (!OPB_Rst && Sl_xferAck) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 1'b1, 1'b0);
      end else begin
        sb_t it;
        it = sbq.pop_front();
        chk("sb_dbus", Sl_DBus, it.dbus);
        chk("sb_strobe", user_wr_strobe, it.strb);
        chk("sb_user_data", user_data_out, model_flat());
      end
    end
  end

  task automatic xfer(input vec_t v, input int id);
    int  lat;
    logic got;
    @(negedge OPB_Clk);
    OPB_ABus = v.addr; OPB_BE = v.be; OPB_DBus = v.data; OPB_RNW = v.rnw; OPB_select = 1'b1;
    if (v.exp_ack) begin
      sbq.push_back('{v.exp_dbus, v.exp_strb});
      if (!v.rnw && v.exp_strb != 4'b0) model[v.ridx] = v.exp_reg;
    end
    lat = 0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge OPB_Clk);
      lat++;
      if (Sl_xferAck) got = 1'b1;
    end
    OPB_select = 1'b0;
    if (v.exp_ack) begin
      chk($sformatf("v%0d_ack_latency", id), lat, 1);
      @(negedge OPB_Clk);
      chk($sformatf("v%0d_after_ack", id), {Sl_xferAck, Sl_DBus, user_wr_strobe}, '0);
    end else begin
      chk($sformatf("v%0d_noack", id), got, 1'b0);
      chk($sformatf("v%0d_noack_outs", id), {Sl_DBus, user_wr_strobe, user_data_out}, {36'b0, model_flat()});
    end
  endtask

  initial begin
    int acks, first, second;
    OPB_Rst = 1'b1; OPB_ABus = '0; OPB_BE = '0; OPB_DBus = '0;
    OPB_RNW = 1'b0; OPB_select = 1'b0; OPB_seqAddr = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;

    // Offsets relative to BASE; be is written in bus order BE[0:3].
    vecs[0]  = mk(BASE+32'h00, 4'b1111, 32'h0,        1, 1, 32'h00000000, 4'b0000, 0, 0);
    vecs[1]  = mk(BASE+32'h04, 4'b1111, 32'hDEADBEEF, 0, 1, 32'h0,        4'b0010, 1, 32'hDEADBEEF);
    vecs[2]  = mk(BASE+32'h04, 4'b0000, 32'h0,        1, 1, 32'hDEADBEEF, 4'b0000, 0, 0);
    // BE[2] only: DBus[16:23]=0x33 lands on register bits [15:8].
    vecs[3]  = mk(BASE+32'h04, 4'b0010, 32'h11223344, 0, 1, 32'h0,        4'b0010, 1, 32'hDEAD33EF);
    vecs[4]  = mk(BASE+32'h04, 4'b1111, 32'h0,        1, 1, 32'hDEAD33EF, 4'b0000, 0, 0);
    vecs[5]  = mk(BASE+32'h0C, 4'b0001, 32'hAABBCCDD, 0, 1, 32'h0,        4'b1000, 3, 32'h000000DD);
    vecs[6]  = mk(BASE+32'h0C, 4'b1111, 32'h0,        1, 1, 32'h000000DD, 4'b0000, 0, 0);
    vecs[7]  = mk(BASE+32'h08, 4'b0000, 32'hFFFFFFFF, 0, 1, 32'h0,        4'b0100, 2, 32'h00000000);
    vecs[8]  = mk(BASE+32'h08, 4'b1111, 32'h0,        1, 1, 32'h00000000, 4'b0000, 0, 0);
    vecs[9]  = mk(BASE+32'h00, 4'b1000, 32'h12345678, 0, 1, 32'h0,        4'b0001, 0, 32'h12000000);
    vecs[10] = mk(BASE+32'h40, 4'b1111, 32'hDEADBEEF, 0, 1, 32'h0,        4'b0000, 0, 0);
    vecs[11] = mk(BASE+32'h40, 4'b1111, 32'h0,        1, 1, 32'h00000000, 4'b0000, 0, 0);
    vecs[12] = mk(BASE+32'h00, 4'b1111, 32'h0,        1, 1, 32'h12000000, 4'b0000, 0, 0);
    vecs[13] = mk(BASE+32'h07, 4'b1111, 32'h0,        1, 1, 32'hDEAD33EF, 4'b0000, 0, 0);
    vecs[14] = mk(32'h01008800, 4'b1111, 32'h0,       1, 0, 32'h0,        4'b0000, 0, 0);
    vecs[15] = mk(32'h010086FC, 4'b1111, 32'hFFFFFFFF, 0, 0, 32'h0,       4'b0000, 0, 0);
    vecs[16] = mk(BASE+32'h3C, 4'b1111, 32'hFFFFFFFF, 0, 1, 32'h0,        4'b0000, 0, 0);

    repeat (2) @(negedge OPB_Clk);
    chk("reset_outs", {Sl_xferAck, Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, user_wr_strobe}, '0);
    chk("reset_user_data", user_data_out, 128'h0);
    OPB_Rst = 1'b0;

    for (int i = 0; i < 17; i++) xfer(vecs[i], i);

    // Select held for six cycles: acks land on cycles 1 and 4.
    @(negedge OPB_Clk);
    OPB_ABus = BASE + 32'h08; OPB_BE = 4'b1111; OPB_DBus = 32'h5A5A5A5A;
    OPB_RNW = 1'b0; OPB_select = 1'b1;
    model[2] = 32'h5A5A5A5A;
    sbq.push_back('{32'h0, 4'b0100});
    sbq.push_back('{32'h0, 4'b0100});
    acks = 0; first = 0; second = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge OPB_Clk);
      if (Sl_xferAck) begin
        acks++;
        if (acks == 1) first = c; else second = c;
      end
    end
    OPB_select = 1'b0;
    chk("hold_ack_count", acks, 2);
    chk("hold_first_ack", first, 1);
    chk("hold_second_ack", second, 4);
    repeat (2) @(negedge OPB_Clk);

    // Reset asserted in the ACK cycle of a write.
    @(negedge OPB_Clk);
    OPB_ABus = BASE; OPB_BE = 4'b1111; OPB_DBus = 32'hCAFEF00D; OPB_RNW = 1'b0; OPB_select = 1'b1;
    @(posedge OPB_Clk); #1;
    chk("rst_pre_ack", Sl_xferAck, 1'b1);
    chk("rst_pre_reg0", user_data_out[31:0], 32'hCAFEF00D);
    OPB_Rst = 1'b1;
    #1;
    chk("rst_ack_drop", {Sl_xferAck, user_wr_strobe, Sl_DBus}, '0);
    chk("rst_regs_clear", user_data_out, 128'h0);
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    OPB_select = 1'b0;
    @(negedge OPB_Clk);
    OPB_Rst = 1'b0;
    for (int i = 0; i < 4; i++)
      xfer(mk(BASE + 32'(4*i), 4'b1111, 32'h0, 1, 1, 32'h0, 4'b0000, 0, 0), 100 + i);

    repeat (2) @(negedge OPB_Clk);
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
